// File: rtl/vec_opa_sel_stage_pkg.sv
// Shared encodings for the vector operand-A selector stage.
// Holds the funct3 format encodings, the SEW codes, and a helper that
// converts a SEW code to an element width in bits.
package vec_opa_sel_stage_pkg;

    // funct3 format encodings
    localparam logic [2:0] VV_FORMAT  = 3'b000;
    localparam logic [2:0] VI_FORMAT  = 3'b011;
    localparam logic [2:0] VX_FORMAT  = 3'b100;
    localparam logic [2:0] MVX_FORMAT = 3'b110;

    // SEW codes
    localparam logic [1:0] SEW_8  = 2'b00;
    localparam logic [1:0] SEW_16 = 2'b01;
    localparam logic [1:0] SEW_32 = 2'b10;
    localparam logic [1:0] SEW_64 = 2'b11;

    // Element width in bits for a SEW code (8 << sew).
    function automatic int unsigned sew_width(input logic [1:0] sew);
        return 32'd8 << sew;
    endfunction

endpackage

// File: rtl/vec_opa_format.sv
// Combinational operand-A formatter.
// Selects VV register data, a replicated scalar (VX/MVX) or a replicated
// sign-extended imm5 (VI) at the current SEW. Unsupported funct3 or SEW
// combinations produce dataA = 0 with illegal = 1.
// Ports:
//   funct3    - vector format field
//   sew       - element width code
//   imm5      - raw simm5 field
//   scalar_in - rs1 value
//   rdvA      - vector register read data
//   dataA     - formatted operand A
//   illegal   - unsupported format / SEW combination
module vec_opa_format
    import vec_opa_sel_stage_pkg::*;
#(
    parameter int unsigned ELEN  = 64,
    parameter int unsigned LANES = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            sew,
    input  logic [4:0]            imm5,
    input  logic [XLEN-1:0]       scalar_in,
    input  logic [ELEN*LANES-1:0] rdvA,
    output logic [ELEN*LANES-1:0] dataA,
    output logic                  illegal
);

    localparam int unsigned DW = ELEN * LANES;

    // Pre-replicated candidates, one per SEW code.
    logic [DW-1:0] imm_rep [4];
    logic [DW-1:0] scl_rep [4];

    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int unsigned W = 32'd8 << g;
        if (W <= ELEN) begin : g_fit
            logic [W-1:0] imm_elem;
            logic [W-1:0] scl_elem;

            assign imm_elem = {{(W-5){imm5[4]}}, imm5};

            if (W <= XLEN) begin : g_scl
                assign scl_elem = scalar_in[W-1:0];
            end else begin : g_no_scl
                assign scl_elem = '0;
            end

            // Copy the element into every SEW-wide slot across all lanes.
            for (genvar s = 0; s < DW / W; s++) begin : g_slot
                assign imm_rep[g][s*W +: W] = imm_elem;
                assign scl_rep[g][s*W +: W] = scl_elem;
            end
        end else begin : g_nofit
            assign imm_rep[g] = '0;
            assign scl_rep[g] = '0;
        end
    end

    int unsigned sew_w;
    assign sew_w = sew_width(sew);

    always_comb begin
        dataA   = '0;
        illegal = 1'b0;
        case (funct3)
            VV_FORMAT: begin
                if (sew_w > ELEN) illegal = 1'b1;
                else              dataA   = rdvA;
            end
            VI_FORMAT: begin
                if (sew_w > ELEN) illegal = 1'b1;
                else              dataA   = imm_rep[sew];
            end
            VX_FORMAT, MVX_FORMAT: begin
                if (sew_w > ELEN || sew_w > XLEN) illegal = 1'b1;
                else                              dataA   = scl_rep[sew];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vec_opa_sel_stage.sv
// Registered vector operand-A selector between ID and EX.
// A valid/ready stage with a two-entry skid buffer (main drives the
// outputs, skid absorbs one request while main is stalled), flush, and a
// per-entry illegal-format flag.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop all held entries and the current request
//   in_valid, in_ready  - upstream handshake
//   funct3, sew, imm5, scalar_in, rdvA - operand request fields
//   out_valid, out_ready - downstream handshake
//   dataA, out_illegal  - formatted operand and illegal flag (0 when idle)
module vec_opa_sel_stage
    import vec_opa_sel_stage_pkg::*;
#(
    parameter int unsigned ELEN  = 64,
    parameter int unsigned LANES = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            funct3,
    input  logic [1:0]            sew,
    input  logic [4:0]            imm5,
    input  logic [XLEN-1:0]       scalar_in,
    input  logic [ELEN*LANES-1:0] rdvA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEN*LANES-1:0] dataA,
    output logic                  out_illegal
);

    localparam int unsigned DW = ELEN * LANES;

    logic [DW-1:0] fmt_data;
    logic          fmt_illegal;

    vec_opa_format #(
        .ELEN  (ELEN),
        .LANES (LANES),
        .XLEN  (XLEN)
    ) u_format (
        .funct3    (funct3),
        .sew       (sew),
        .imm5      (imm5),
        .scalar_in (scalar_in),
        .rdvA      (rdvA),
        .dataA     (fmt_data),
        .illegal   (fmt_illegal)
    );

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    logic          main_ill_q,   main_ill_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          skid_ill_q,   skid_ill_d;

    logic accept;
    logic xfer;

    always_comb begin
        accept       = in_valid && !skid_valid_q;
        xfer         = main_valid_q && out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ill_d   = skid_ill_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            // Main is free this cycle: refill from skid first to keep FIFO order.
            // in_ready is low whenever skid is valid, so no accept can collide.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = fmt_data;
                    main_ill_d  = fmt_illegal;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = fmt_data;
            skid_ill_d   = fmt_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    // Data registers are not cleared by flush, so gate them when idle.
    assign dataA       = main_valid_q ? main_data_q : '0;
    assign out_illegal = main_valid_q & main_ill_q;

endmodule

// File: tb/tb_vec_opa_sel_stage.sv
// Self-checking bench for vec_opa_sel_stage (ELEN=64, LANES=4, XLEN=64).
// Expected results are pushed to a scoreboard queue on accept and popped by
// a negedge monitor on each output transfer.
module tb_vec_opa_sel_stage;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [2:0]    funct3;
    logic [1:0]    sew;
    logic [4:0]    imm5;
    logic [63:0]   scalar_in;
    logic [DW-1:0] rdvA, dataA;

    always #5 clk = ~clk;

    vec_opa_sel_stage #(
        .ELEN  (64),
        .LANES (4),
        .XLEN  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .funct3      (funct3),
        .sew         (sew),
        .imm5        (imm5),
        .scalar_in   (scalar_in),
        .rdvA        (rdvA),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dataA       (dataA),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [2:0]    f3;
        logic [1:0]    sew;
        logic [4:0]    imm;
        logic [63:0]   scl;
        logic [DW-1:0] rdv;
        logic [DW-1:0] exp_data;
        logic          exp_ill;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[13];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endfunction

    // Output monitor: pops and compares on every transfer; idle outputs must read 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", DW'(1), DW'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("dataA", dataA, mon_e.data);
                    check("out_illegal", DW'(out_illegal), DW'(mon_e.ill));
                end
            end else if (!out_valid) begin
                check("idle_dataA", dataA, DW'(0));
                check("idle_illegal", DW'(out_illegal), DW'(0));
            end
        end
    end

    task automatic present(input vec_t v);
        funct3    = v.f3;
        sew       = v.sew;
        imm5      = v.imm;
        scalar_in = v.scl;
        rdvA      = v.rdv;
        in_valid  = 1'b1;
    endtask

    // Present a request until accepted; returns stall cycles. Leaves in_valid high.
    task automatic send(input vec_t v, output int waits);
        logic acc;
        present(v);
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 50) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) sb.push_back('{v.exp_data, v.exp_ill});
            else     waits++;
        end
        if (!acc) check("accept_timeout", DW'(1), DW'(0));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [DW-1:0] p;
        p = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0011223344556677;

        tbl[0]  = '{3'b011, 2'b00, 5'b11110, 64'h0, '0, {32{8'hFE}}, 1'b0};
        tbl[1]  = '{3'b100, 2'b10, 5'b0, 64'h1234_5678_9ABC_DEF0, '0, {8{32'h9ABCDEF0}}, 1'b0};
        tbl[2]  = '{3'b000, 2'b11, 5'b0, 64'h0, p, p, 1'b0};
        tbl[3]  = '{3'b001, 2'b00, 5'b0, 64'hFFFF, p, '0, 1'b1};
        tbl[4]  = '{3'b011, 2'b11, 5'b01111, 64'h0, '0, {4{64'h000000000000000F}}, 1'b0};
        tbl[5]  = '{3'b011, 2'b01, 5'b10000, 64'h0, '0, {16{16'hFFF0}}, 1'b0};
        tbl[6]  = '{3'b110, 2'b11, 5'b0, 64'h1234_5678_9ABC_DEF0, '0,
                    {4{64'h123456789ABCDEF0}}, 1'b0};
        tbl[7]  = '{3'b100, 2'b00, 5'b0, 64'h1234_5678_9ABC_DEF0, '0, {32{8'hF0}}, 1'b0};
        tbl[8]  = '{3'b110, 2'b01, 5'b0, 64'h1234_5678_9ABC_DEF0, '0, {16{16'hDEF0}}, 1'b0};
        tbl[9]  = '{3'b111, 2'b10, 5'b11111, 64'h55, p, '0, 1'b1};
        tbl[10] = '{3'b011, 2'b10, 5'b00000, 64'h0, p, '0, 1'b0};
        tbl[11] = '{3'b011, 2'b10, 5'b10101, 64'h0, '0, {8{32'hFFFFFFF5}}, 1'b0};
        tbl[12] = '{3'b010, 2'b00, 5'b00001, 64'h1, p, '0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; sew = '0; imm5 = '0; scalar_in = '0; rdvA = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", DW'(out_valid), DW'(0));
        check("reset_dataA", dataA, DW'(0));
        check("reset_illegal", DW'(out_illegal), DW'(0));
        check("reset_in_ready", DW'(in_ready), DW'(1));

        // Table: back-to-back at full throughput.
        for (int i = 0; i < 13; i++) begin
            send(tbl[i], w);
            check("throughput_stall", DW'(w), DW'(0));
        end
        idle(3);
        check("table_drained", DW'(sb.size()), DW'(0));

        // Backpressure: A held, B into skid, C stalls; then A, B, C drain in order.
        out_ready = 1'b0;
        send(tbl[1], w);
        check("bp_a_ready", DW'(w), DW'(0));
        send(tbl[3], w);
        check("bp_b_ready", DW'(w), DW'(0));
        present(tbl[6]);
        check("bp_full_in_ready", DW'(in_ready), DW'(0));
        @(posedge clk); #1;
        check("bp_stall_in_ready", DW'(in_ready), DW'(0));
        check("bp_held_valid", DW'(out_valid), DW'(1));
        check("bp_held_data", dataA, tbl[1].exp_data);
        out_ready = 1'b1;
        send(tbl[6], w);
        check("bp_c_stall", DW'(w), DW'(1));
        idle(3);
        check("bp_drained", DW'(sb.size()), DW'(0));

        // Flush with both entries full and a request presented.
        out_ready = 1'b0;
        send(tbl[0], w);
        send(tbl[4], w);
        present(tbl[5]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", DW'(out_valid), DW'(0));
        check("flush_in_ready", DW'(in_ready), DW'(1));
        check("flush_dataA", dataA, DW'(0));
        out_ready = 1'b1;
        idle(3);

        // Flush takes priority over an accept into an empty stage.
        present(tbl[7]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_prio_valid", DW'(out_valid), DW'(0));
        idle(2);

        // Reset mid-stream with out_ready toggling.
        out_ready = 1'b0;
        send(tbl[8], w);
        out_ready = 1'b1;
        send(tbl[11], w);
        out_ready = 1'b0;
        send(tbl[9], w);
        present(tbl[2]);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_dataA", dataA, DW'(0));
        check("rst_illegal", DW'(out_illegal), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        send(tbl[12], w);
        in_valid = 1'b0;
        check("post_rst_latency_valid", DW'(out_valid), DW'(1));
        check("post_rst_illegal", DW'(out_illegal), DW'(1));
        idle(3);
        check("final_drained", DW'(sb.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_opa_sel_stage.md
Name: vec_opa_sel_stage

Overview:
- Parametrised, registered successor to the vector operand-A format selector.
- Per funct3, builds operand A for LANES x ELEN-bit lanes from one of three sources: vector register read data (VV), scalar rs1 (VX/MVX), or sign-extended imm5 (VI).
- Scalar and immediate sources are replicated at the current SEW.
- Sits between ID and EX as a valid/ready pipeline stage with a 2-entry skid buffer, flush, and an illegal-format flag.

Parameters:
- ELEN, 64, lane width in bits (power of two, >=32).
- LANES, 4, number of lanes; dataA width is ELEN*LANES.
- XLEN, 64, scalar operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drops all held entries
- in_valid  in  1  upstream has an operand request
- in_ready  out  1  stage can accept a request
- funct3  in  3  vector format field
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=64
- imm5  in  5  raw simm5 field
- scalar_in  in  XLEN  rs1 value
- rdvA  in  ELEN*LANES  vector register read data
- out_valid  out  1  dataA valid
- out_ready  in  1  downstream accepts
- dataA  out  ELEN*LANES  formatted operand A
- out_illegal  out  1  funct3 or sew combination was unsupported

Behaviour:
- Reset: all valids 0; dataA 0; out_illegal 0; in_ready 1 in the cycle after rst deasserts. Reset mid-transfer discards held entries.
- Clock and reset: one clock domain; reset is synchronous and active-high, sampled on rising clk.
- Format encodings, from constants.vh:
  - VV_FORMAT 3'b000: dataA = rdvA.
  - VI_FORMAT 3'b011: elem = sign-extended imm5 at SEW.
  - VX_FORMAT 3'b100 and MVX_FORMAT 3'b110: elem = scalar_in[SEW-1:0].
  - Any other funct3: dataA = 0, out_illegal = 1.
- Replication: elem is copied into every SEW-wide slot of every lane; with SEW=ELEN, one copy per lane.
- SEW limits:
  - SEW > ELEN or SEW > XLEN (VX only) is illegal: dataA = 0, out_illegal = 1.
  - For ELEN=32, sew=11 is illegal.
- Formatting is combinational on the inputs; the result is captured at accept.
- Handshake:
  - Accept when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Inputs must be held stable while in_valid && !in_ready.
  - Latency is 1 cycle from accept to out_valid; full throughput, 1 per cycle, with out_ready held high.
- Skid buffer, two entries: main (drives outputs) and skid.
  - in_ready = !skid_valid, registered.
  - Accept while main is empty, or main transfers the same cycle: load main.
  - Accept while main is held (out_valid && !out_ready): load skid.
  - Main transfers while skid is valid: skid moves to main, skid clears.
  - Main transfers while skid is empty and no accept: main_valid clears.
  - Full means both entries valid: in_ready=0; out_valid stays 1 until out_ready.
- Ordering: strict FIFO; no reordering, no drop except on flush or rst.
- Flush: synchronous, priority over accept in the same cycle. Next cycle: out_valid=0, skid empty, in_ready=1; the request presented in the flush cycle is discarded. Data registers need not clear, but dataA reads 0 while out_valid=0 (gated).
- out_illegal is a per-entry bit travelling with its data; valid only while out_valid=1, else 0.

Decomposition:
- constants.vh holds:
  - funct3 encodings VV_FORMAT, VI_FORMAT, VX_FORMAT, MVX_FORMAT.
  - SEW codes SEW_8/16/32/64.
- Sub-module vec_opa_format: purely combinational funct3/sew/imm5/scalar/rdvA to {dataA, illegal}, replication via generate loops.
- Top vec_opa_sel_stage: main/skid registers plus handshake control only.

Test Plan:
- VI, sew=00, imm5=5'b11110, ELEN=64, LANES=4; accept -> next cycle out_valid=1, dataA = all bytes 8'hFE (256'hFEFE...FE), out_illegal=0.
- VX, sew=10, scalar_in=64'h1234_5678_9ABC_DEF0 -> every lane = 64'h9ABCDEF0_9ABCDEF0; VV with rdvA=pattern P -> dataA=P exactly.
- Illegal: funct3=3'b001 -> dataA=0, out_illegal=1, handshake completes normally.
- Backpressure: out_ready=0 and three back-to-back requests A,B,C -> A held on output, B in skid, in_ready=0 from cycle after B, C stalls. Raise out_ready -> A, B, C emerge in order, one per cycle.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; no further output from those entries or the flush-cycle request.
- rst asserted mid-stream with out_ready toggling -> next cycle all outputs 0 and in_ready=1; a post-reset request emerges with 1-cycle latency.
